instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : Single-outstanding instruction fetch with redirect flush and a
//               one-entry output slot toward decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    input  logic        i_ready
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] instr_q, instr_d;

    logic        w_slot_free;
    logic        w_req;
    logic        w_grant;
    logic        w_load;
    logic [31:0] w_redirect_tgt;

    assign w_slot_free    = !valid_q || i_ready;
    // Gated by reset so no request escapes while the block is held in reset.
    assign w_req          = i_rst_n && (state_q == S_REQ) && w_slot_free;
    assign w_grant        = w_req && i_imem_gnt;
    assign w_redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;

    assign o_imem_req    = w_req;
    assign o_imem_addr   = pc_q;
    assign o_valid       = valid_q;
    assign o_pc          = opc_q;
    assign o_instruction = instr_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        w_load   = 1'b0;

        case (state_q)
            S_REQ: begin
                if (w_grant) begin
                    req_pc_d = pc_q;
                end
                if (i_redirect) begin
                    pc_d    = w_redirect_tgt;
                    state_d = w_grant ? S_DRAIN : S_REQ;
                end else if (w_grant) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    pc_d    = w_redirect_tgt;
                    state_d = i_imem_rvalid ? S_REQ : S_DRAIN;
                end else if (i_imem_rvalid) begin
                    w_load  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_redirect) begin
                    pc_d = w_redirect_tgt;
                end
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        if (i_redirect) begin
            valid_d = 1'b0;
        end else if (w_load) begin
            valid_d = 1'b1;
            opc_d   = req_pc_q;
            instr_d = i_imem_rdata;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            valid_q  <= 1'b0;
            opc_q    <= 32'h0;
            instr_q  <= C_NOP;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            valid_q  <= valid_d;
            opc_q    <= opc_d;
            instr_q  <= instr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Randomized bench for instruction_fetch against a transaction
//               model of the fetch stream and a latency-varying memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        i_ready;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .i_ready       (i_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: one pending transaction (live or flushed), the visible output slot,
    // and the address the next request must carry.
    bit          m_valid;
    logic [31:0] m_pc, m_instr;
    bit          m_pend, m_pend_live;
    logic [31:0] m_pend_addr;
    logic [31:0] m_fetch;
    int          m_lat;
    int          max_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h13;
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_pc        = 32'h0;
        m_instr     = 32'h0000_0013;
        m_pend      = 1'b0;
        m_pend_live = 1'b0;
        m_pend_addr = 32'h0;
        m_fetch     = RESET_PC;
        m_lat       = 0;
    endtask

    task automatic step(input bit gnt, input bit rdy, input bit redir,
                        input logic [31:0] rpc, input bit junk_rv);
        bit rv, req, granted, take;
        @(negedge clk);
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_pc", o_pc, m_pc);
        chk("o_instruction", o_instruction, m_instr);

        rv            = m_pend ? (m_lat == 0) : junk_rv;
        i_imem_gnt    = gnt;
        i_ready       = rdy;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_rvalid = rv;
        i_imem_rdata  = (rv && m_pend) ? mem_word(m_pend_addr) : $urandom;
        #1;
        req = !m_pend && (!m_valid || rdy);
        chk("o_imem_req", 32'(o_imem_req), 32'(req));
        if (req) chk("o_imem_addr", o_imem_addr, m_fetch);

        granted = req && gnt;
        take    = rv && m_pend;
        if (redir) begin
            m_valid = 1'b0;
        end else if (take && m_pend_live) begin
            m_valid = 1'b1;
            m_pc    = m_pend_addr;
            m_instr = mem_word(m_pend_addr);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end

        if (take) m_pend = 1'b0;
        else if (m_pend && m_lat > 0) m_lat--;

        if (granted) begin
            m_pend      = 1'b1;
            m_pend_addr = m_fetch;
            m_pend_live = !redir;
            m_lat       = $urandom_range(0, max_lat);
            m_fetch     = m_fetch + 32'd4;
        end else if (redir) begin
            m_pend_live = 1'b0;
        end
        if (redir) m_fetch = rpc & 32'hFFFF_FFFC;
    endtask

    // Asynchronous reset pulse; a stale response arrives right after release.
    task automatic do_reset();
        @(negedge clk);
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_o_instruction", o_instruction, 32'h0000_0013);
        chk("rst_o_pc", o_pc, 32'h0);
        chk("rst_o_imem_req", 32'(o_imem_req), 32'h0);
        model_reset();
        i_imem_gnt    = 1'b0;
        i_redirect    = 1'b0;
        i_imem_rvalid = 1'b1;
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_ready       = 1'b0;
        max_lat       = 0;
        model_reset();

        @(negedge clk);
        chk("init_o_valid", 32'(o_valid), 32'h0);
        chk("init_o_instruction", o_instruction, 32'h0000_0013);
        chk("init_o_pc", o_pc, 32'h0);
        chk("init_o_imem_req", 32'(o_imem_req), 32'h0);
        i_rst_n = 1'b1;

        // Streaming fetch across the 32-bit address wrap.
        repeat (14) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Decode stall, then release.
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect coinciding with a grant, to an unaligned target.
        for (int i = 0; i < 10; i++) begin
            if (!m_pend) begin
                step(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b0);
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while a live request is waiting for its data.
        max_lat = 2;
        for (int i = 0; i < 10; i++) begin
            if (m_pend && m_pend_live && m_lat > 0) begin
                step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
                break;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        max_lat = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 250) begin
                for (int j = 0; j < 20 && !m_pend; j++)
                    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
                do_reset();
                step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
